mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, SHALL set the number of consecutive data grants after which a waiting fetch wins; legal range 1..15.
REQ-002 clk_i  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n_i  in  1  reset; SHALL be asynchronous and active-low.
REQ-004 if_req_i / if_addr_i  in  1 / 32  fetch request, held until if_valid_o.
REQ-005 if_flush_i  in  1  branch/jump redirect; pending fetch result SHALL be discarded.
REQ-006 if_rdata_o / if_valid_o  out  32 / 1  fetch data with one-cycle completion strobe.
REQ-007 dm_req_i / dm_we_i / dm_addr_i / dm_wdata_i / dm_be_i  in  1/1/32/32/4  load/store request, held until dm_valid_o.
REQ-008 dm_rdata_o / dm_valid_o  out  32 / 1  load data with one-cycle completion strobe; stores also strobe.
REQ-009 mem_req_o / mem_we_o / mem_addr_o / mem_wdata_o / mem_be_o  out  1/1/32/32/4  shared memory port request.
REQ-010 mem_gnt_i  in  1  memory accepts request in the cycle mem_req_o and mem_gnt_i are both high.
REQ-011 mem_rvalid_i / mem_rdata_i  in  1 / 32  response, at least one cycle after the grant cycle.
REQ-012 stall_if_o / stall_dm_o  out  1 / 1  pipeline stall requests for fetch and memory stages.

Function
REQ-013 FSM states SHALL be IDLE, REQ, WAIT; at most one transaction outstanding.
REQ-014 IDLE: if any req_i high, SHALL select owner, register address/control/data, move to REQ next cycle.
REQ-015 Selection: DM wins over IF, except IF wins when both request and starve count equals STARVE_LIMIT.
REQ-016 Starve count (4-bit) SHALL increment on each DM selection while if_req_i high, saturate at STARVE_LIMIT, clear on IF selection.
REQ-017 REQ: mem_req_o SHALL be 1 with registered fields stable; request SHALL NOT be withdrawn; on mem_gnt_i go to WAIT.
REQ-018 WAIT: on mem_rvalid_i SHALL return to IDLE; no new arbitration in that cycle (min 3 cycles per transaction).
REQ-019 if_valid_o SHALL equal mem_rvalid_i in WAIT with owner IF and squash clear; dm_valid_o likewise for owner DM; rdata outputs pass mem_rdata_i combinationally.
REQ-020 if_flush_i in REQ or WAIT with owner IF SHALL set squash; flush coincident with mem_rvalid_i SHALL suppress if_valid_o; squash clears on return to IDLE.
REQ-021 if_flush_i with owner DM or in IDLE SHALL have no effect.
REQ-022 mem_gnt_i outside REQ and mem_rvalid_i outside WAIT SHALL be ignored.
REQ-023 stall_if_o = if_req_i and not if_valid_o; stall_dm_o = dm_req_i and not dm_valid_o.
REQ-024 mem_we_o/mem_be_o SHALL be 0/0000 for fetches; mem_wdata_o don't-care for reads.

Reset
REQ-025 Reset SHALL force IDLE, squash 0, starve count 0, mem_req_o 0, registered fields 0, immediately (asynchronous).
REQ-026 Reset mid-transaction SHALL abandon it; a later mem_rvalid_i SHALL NOT produce any valid strobe.

Structure
REQ-027 Package mem_arb_pkg SHALL hold the state enum (IDLE/REQ/WAIT), owner enum (OWN_IF/OWN_DM) and XLEN=32.
REQ-028 Single module, no sub-modules.

Verification
REQ-029 IF only, addr 0x0000_0010, gnt same cycle, rvalid 1 cycle later, rdata 0x0013_0513 -> if_valid_o 1 cycle with that data, stall_if_o low that cycle.
REQ-030 IF and DM both request from IDLE, STARVE_LIMIT=4 -> DM served first; after 4 back-to-back DM loads with IF waiting, 5th arbitration grants IF.
REQ-031 IF owner in WAIT, if_flush_i pulse, then rvalid -> no if_valid_o, FSM IDLE next cycle, new fetch accepted.
REQ-032 DM store addr 0x100, be 4'b0011, gnt delayed 3 cycles -> mem_req_o and fields stable for 4 cycles, dm_valid_o on rvalid.
REQ-033 rst_n_i low in WAIT, released, stray rvalid -> mem_req_o 0 immediately, no valid strobes, counters 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

    localparam int XLEN = 32;
    localparam int BE_W = XLEN / 8;

    // Transaction phases: arbitrate, present the request, await the response.
    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } arb_state_e;

    // Which pipeline stage owns the transaction in flight.
    typedef enum logic {
        OWN_IF,
        OWN_DM
    } arb_owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data memory.
// Only one transaction is outstanding at a time. Data accesses normally
// win arbitration. A waiting fetch wins once it has been passed over
// STARVE_LIMIT times in a row.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            if_req_i,
    input  logic [XLEN-1:0] if_addr_i,
    input  logic            if_flush_i,
    output logic [XLEN-1:0] if_rdata_o,
    output logic            if_valid_o,
    input  logic            dm_req_i,
    input  logic            dm_we_i,
    input  logic [XLEN-1:0] dm_addr_i,
    input  logic [XLEN-1:0] dm_wdata_i,
    input  logic [BE_W-1:0] dm_be_i,
    output logic [XLEN-1:0] dm_rdata_o,
    output logic            dm_valid_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [BE_W-1:0] mem_be_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            stall_if_o,
    output logic            stall_dm_o
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_e      state_q,  state_d;
    arb_owner_e      owner_q,  owner_d;
    logic            squash_q, squash_d;
    logic [3:0]      starve_q, starve_d;
    logic [XLEN-1:0] addr_q,   addr_d;
    logic            we_q,     we_d;
    logic [XLEN-1:0] wdata_q,  wdata_d;
    logic [BE_W-1:0] be_q,     be_d;

    logic sel_if;
    logic flush_hit;
    logic resp_hit;

    // Arbitration choice, and the qualifiers for flush and response.
    always_comb begin
        sel_if    = if_req_i && (!dm_req_i || (starve_q == LIMIT));
        flush_hit = if_flush_i && (owner_q == OWN_IF);
        resp_hit  = (state_q == WAIT) && mem_rvalid_i;
    end

    // Next-state logic: arbitrate in IDLE, hold the request until granted, then await the response.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        squash_d = squash_q;
        starve_d = starve_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        unique case (state_q)
            IDLE: begin
                squash_d = 1'b0;
                if (if_req_i || dm_req_i) begin
                    state_d = REQ;
                    if (sel_if) begin
                        owner_d  = OWN_IF;
                        addr_d   = if_addr_i;
                        we_d     = 1'b0;
                        wdata_d  = '0;
                        be_d     = '0;
                        starve_d = '0;
                    end else begin
                        owner_d = OWN_DM;
                        addr_d  = dm_addr_i;
                        we_d    = dm_we_i;
                        wdata_d = dm_wdata_i;
                        be_d    = dm_be_i;
                        if (if_req_i && (starve_q < LIMIT)) begin
                            starve_d = starve_q + 4'd1;
                        end
                    end
                end
            end
            REQ: begin
                if (flush_hit) begin
                    squash_d = 1'b1;
                end
                if (mem_gnt_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (flush_hit) begin
                    squash_d = 1'b1;
                end
                if (mem_rvalid_i) begin
                    state_d  = IDLE;
                    squash_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and request registers; reset abandons any transaction immediately.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            owner_q  <= OWN_IF;
            squash_q <= 1'b0;
            starve_q <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            be_q     <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            squash_q <= squash_d;
            starve_q <= starve_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
        end
    end

    // Port outputs: registered request fields, response strobes routed to the owner, and stalls.
    always_comb begin
        mem_req_o   = (state_q == REQ);
        mem_we_o    = we_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        mem_be_o    = be_q;
        if_valid_o  = resp_hit && (owner_q == OWN_IF) && !squash_q && !if_flush_i;
        dm_valid_o  = resp_hit && (owner_q == OWN_DM);
        if_rdata_o  = mem_rdata_i;
        dm_rdata_o  = mem_rdata_i;
        stall_if_o  = if_req_i && !if_valid_o;
        stall_dm_o  = dm_req_i && !dm_valid_o;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. A behavioural memory answers
// the shared port. Expected response data is queued per requester when a
// request is driven, and is compared when the matching valid strobe appears.
module tb_mem_port_arbiter;

    localparam int STARVE_LIMIT = 4;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_flush_i;
    logic [31:0] if_rdata_o;
    logic        if_valid_o;
    logic        dm_req_i;
    logic        dm_we_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic [3:0]  dm_be_i;
    logic [31:0] dm_rdata_o;
    logic        dm_valid_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        stall_if_o;
    logic        stall_dm_o;

    int checkCount = 0;
    int errorCount = 0;

    logic [31:0] ifQ[$];
    logic [31:0] dmQ[$];
    logic [36:0] grantLog[$];

    int gntDelay = 0;
    int rspDelay = 1;
    int ifValidCnt = 0;
    int dmValidCnt = 0;

    mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_flush_i  (if_flush_i),
        .if_rdata_o  (if_rdata_o),
        .if_valid_o  (if_valid_o),
        .dm_req_i    (dm_req_i),
        .dm_we_i     (dm_we_i),
        .dm_addr_i   (dm_addr_i),
        .dm_wdata_i  (dm_wdata_i),
        .dm_be_i     (dm_be_i),
        .dm_rdata_o  (dm_rdata_o),
        .dm_valid_o  (dm_valid_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_be_o    (mem_be_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i (mem_rdata_i),
        .stall_if_o  (stall_if_o),
        .stall_dm_o  (stall_dm_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory contents as seen by the bench; address 0x10 holds a known instruction.
    function automatic logic [31:0] memData(input logic [31:0] a);
        return (a == 32'h10) ? 32'h0013_0513 : ((a ^ 32'hC0DE_0000) + 32'h1);
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drives one request on a port, holds it until its valid strobe, and reports the cycle count.
    task automatic applyStimulus(input bit isIf, input bit we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be, output int latency);
        bit    done;
        string tag;
        done    = 1'b0;
        latency = 0;
        if (isIf) begin
            tag       = "ifTimeout";
            if_req_i  = 1'b1;
            if_addr_i = addr;
            ifQ.push_back(memData(addr));
        end else begin
            tag        = "dmTimeout";
            dm_req_i   = 1'b1;
            dm_we_i    = we;
            dm_addr_i  = addr;
            dm_wdata_i = wdata;
            dm_be_i    = be;
            dmQ.push_back(memData(addr));
        end
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk_i);
            latency++;
            done = isIf ? if_valid_o : dm_valid_o;
        end
        checkOutput(tag, done, 1);
        @(posedge clk_i);
        #1;
        if (isIf) if_req_i = 1'b0;
        else      dm_req_i = 1'b0;
    endtask

    // Waits for the cycle in which the memory accepts the pending request.
    task automatic waitGrant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk_i);
            ok = mem_req_o && mem_gnt_i;
        end
    endtask

    task automatic doReset();
        rst_n_i    = 1'b0;
        if_req_i   = 1'b0;
        if_addr_i  = '0;
        if_flush_i = 1'b0;
        dm_req_i   = 1'b0;
        dm_we_i    = 1'b0;
        dm_addr_i  = '0;
        dm_wdata_i = '0;
        dm_be_i    = '0;
        @(posedge clk_i);
        @(posedge clk_i);
        #3;
        rst_n_i = 1'b1;
    endtask

    // Memory model: grants after gntDelay waiting cycles, responds rspDelay cycles after the grant.
    initial begin
        int waitCnt;
        int rspCnt;
        logic [31:0] rspData;
        waitCnt      = 0;
        rspCnt       = 0;
        rspData      = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'hDEAD_BEEF;
        forever begin
            @(posedge clk_i);
            #1;
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = 32'hDEAD_BEEF;
            if (!rst_n_i) waitCnt = 0;
            if (rspCnt > 0) begin
                rspCnt--;
                if (rspCnt == 0) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = rspData;
                end
            end else if (mem_req_o && rst_n_i) begin
                if (waitCnt >= gntDelay) begin
                    mem_gnt_i = 1'b1;
                    waitCnt   = 0;
                    rspCnt    = rspDelay;
                    rspData   = memData(mem_addr_o);
                    grantLog.push_back({mem_we_o, mem_be_o, mem_addr_o});
                end else begin
                    waitCnt++;
                end
            end
        end
    end

    // Scoreboard: every valid strobe must match the oldest outstanding request of its port.
    initial begin
        forever begin
            @(negedge clk_i);
            if (if_valid_o) begin
                ifValidCnt++;
                checkOutput("ifStallOnValid", stall_if_o, 0);
                checkOutput("ifQueueHasEntry", ifQ.size() > 0, 1);
                if (ifQ.size() > 0) checkOutput("ifRdata", if_rdata_o, ifQ.pop_front());
            end
            if (dm_valid_o) begin
                dmValidCnt++;
                checkOutput("dmStallOnValid", stall_dm_o, 0);
                checkOutput("dmQueueHasEntry", dmQ.size() > 0, 1);
                if (dmQ.size() > 0) checkOutput("dmRdata", dm_rdata_o, dmQ.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired got=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat;
        int latIf;
        int latDm;
        int reqCycles;
        int dmBefore;
        int ifBefore;
        bit ok;
        bit seen;
        bit reqSeen;
        logic [31:0] expOrder[6];

        // Reset state
        rst_n_i    = 1'b0;
        if_req_i   = 1'b0;
        if_addr_i  = '0;
        if_flush_i = 1'b0;
        dm_req_i   = 1'b0;
        dm_we_i    = 1'b0;
        dm_addr_i  = '0;
        dm_wdata_i = '0;
        dm_be_i    = '0;
        #1;
        checkOutput("resetMemReq", mem_req_o, 0);
        checkOutput("resetFields", {mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o}, 0);
        checkOutput("resetValids", {if_valid_o, dm_valid_o}, 0);
        @(posedge clk_i);
        @(posedge clk_i);
        #3;
        rst_n_i = 1'b1;

        // Lone fetch, same-cycle grant, response one cycle later
        $display("[TB] lone fetch");
        gntDelay = 0;
        rspDelay = 1;
        grantLog.delete();
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, lat);
        checkOutput("fetchLatency", lat, 3);
        checkOutput("fetchGrantCount", grantLog.size(), 1);
        checkOutput("fetchGrantFields", grantLog[0], {1'b0, 4'b0000, 32'h10});

        // Starvation: four data loads first, then the waiting fetch
        $display("[TB] starvation limit");
        doReset();
        grantLog.delete();
        fork
            applyStimulus(1'b1, 1'b0, 32'h200, 32'h0, 4'h0, latIf);
            begin
                for (int k = 0; k < 5; k++)
                    applyStimulus(1'b0, 1'b0, 32'h300 + 32'(4 * k), 32'h0, 4'hF, latDm);
            end
        join
        expOrder = '{32'h300, 32'h304, 32'h308, 32'h30C, 32'h200, 32'h310};
        checkOutput("starveGrantCount", grantLog.size(), 6);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("starveOrder%0d", i), grantLog[i][31:0], expOrder[i]);
        end

        // Flush while waiting for a fetch response
        $display("[TB] flush in WAIT");
        rspDelay  = 3;
        if_req_i  = 1'b1;
        if_addr_i = 32'h20;
        waitGrant(ok);
        checkOutput("flushGrantSeen", ok, 1);
        checkOutput("flushStallIf", stall_if_o, 1);
        @(posedge clk_i);
        #1;
        if_flush_i = 1'b1;
        if_req_i   = 1'b0;
        @(posedge clk_i);
        #1;
        if_flush_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_i);
            if (mem_rvalid_i) begin
                seen = 1'b1;
                checkOutput("flushedNoValid", if_valid_o, 0);
            end
        end
        checkOutput("flushRvalidSeen", seen, 1);
        @(posedge clk_i);
        #1;
        rspDelay = 1;
        applyStimulus(1'b1, 1'b0, 32'h24, 32'h0, 4'h0, lat);
        checkOutput("postFlushLatency", lat, 3);

        // Flush in the same cycle as the response
        $display("[TB] flush coincident with response");
        rspDelay  = 2;
        if_req_i  = 1'b1;
        if_addr_i = 32'h28;
        waitGrant(ok);
        checkOutput("coincGrantSeen", ok, 1);
        @(posedge clk_i);
        #1;
        @(posedge clk_i);
        #1;
        if_flush_i = 1'b1;
        if_req_i   = 1'b0;
        @(negedge clk_i);
        checkOutput("coincRvalid", mem_rvalid_i, 1);
        checkOutput("coincNoValid", if_valid_o, 0);
        @(posedge clk_i);
        #1;
        if_flush_i = 1'b0;
        rspDelay   = 1;
        applyStimulus(1'b1, 1'b0, 32'h2C, 32'h0, 4'h0, lat);
        checkOutput("postCoincLatency", lat, 3);

        // Store with delayed grant; a held fetch flush must not disturb it
        $display("[TB] delayed-grant store");
        gntDelay   = 3;
        if_flush_i = 1'b1;
        dm_req_i   = 1'b1;
        dm_we_i    = 1'b1;
        dm_addr_i  = 32'h100;
        dm_wdata_i = 32'hCAFE_F00D;
        dm_be_i    = 4'b0011;
        dmQ.push_back(memData(32'h100));
        reqCycles = 0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk_i);
            if (mem_req_o) begin
                reqCycles++;
                checkOutput("storeFields", {mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o},
                            {1'b1, 32'h100, 32'hCAFE_F00D, 4'b0011});
                checkOutput("storeStall", stall_dm_o, 1);
            end
            seen = dm_valid_o;
        end
        checkOutput("storeReqCycles", reqCycles, 4);
        checkOutput("storeDone", seen, 1);
        @(posedge clk_i);
        #1;
        dm_req_i   = 1'b0;
        dm_we_i    = 1'b0;
        if_flush_i = 1'b0;

        // Asynchronous reset while a request is presented
        $display("[TB] reset during REQ");
        gntDelay  = 20;
        if_req_i  = 1'b1;
        if_addr_i = 32'h30;
        @(negedge clk_i);
        @(negedge clk_i);
        checkOutput("preResetReq", mem_req_o, 1);
        #2;
        rst_n_i  = 1'b0;
        if_req_i = 1'b0;
        #1;
        checkOutput("asyncResetReq", mem_req_o, 0);
        checkOutput("asyncResetAddr", mem_addr_o, 0);
        @(posedge clk_i);
        @(posedge clk_i);
        #3;
        rst_n_i  = 1'b1;
        gntDelay = 0;

        // Reset while waiting: stray response ignored, starve count cleared
        $display("[TB] reset during WAIT");
        doReset();
        rspDelay  = 1;
        if_req_i  = 1'b1;
        if_addr_i = 32'h400;
        for (int k = 0; k < 3; k++)
            applyStimulus(1'b0, 1'b0, 32'h500 + 32'(4 * k), 32'h0, 4'hF, latDm);
        rspDelay  = 5;
        dm_req_i  = 1'b1;
        dm_we_i   = 1'b0;
        dm_addr_i = 32'h50C;
        waitGrant(ok);
        checkOutput("waitGrantSeen", ok, 1);
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        #2;
        rst_n_i  = 1'b0;
        if_req_i = 1'b0;
        dm_req_i = 1'b0;
        #1;
        checkOutput("resetWaitReq", mem_req_o, 0);
        dmBefore = dmValidCnt;
        ifBefore = ifValidCnt;
        @(posedge clk_i);
        @(posedge clk_i);
        #3;
        rst_n_i = 1'b1;
        seen    = 1'b0;
        reqSeen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            seen    = seen | mem_rvalid_i;
            reqSeen = reqSeen | mem_req_o;
        end
        checkOutput("strayRvalidSeen", seen, 1);
        checkOutput("noReqAfterReset", reqSeen, 0);
        checkOutput("noDmStrobe", dmValidCnt - dmBefore, 0);
        checkOutput("noIfStrobe", ifValidCnt - ifBefore, 0);
        @(posedge clk_i);
        #1;
        rspDelay = 1;
        grantLog.delete();
        fork
            applyStimulus(1'b1, 1'b0, 32'h400, 32'h0, 4'h0, latIf);
            applyStimulus(1'b0, 1'b0, 32'h600, 32'h0, 4'hF, latDm);
        join
        checkOutput("postResetGrantCount", grantLog.size(), 2);
        checkOutput("postResetFirstDm", grantLog[0][31:0], 32'h600);
        checkOutput("postResetSecondIf", grantLog[1][31:0], 32'h400);

        checkOutput("ifQueueDrained", ifQ.size(), 0);
        checkOutput("dmQueueDrained", dmQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
